muldiv_unit: RTL and testbench

//  Parametrised iterative multiply/divide unit in EX; next generation of the ALU multiplier path.

---
 rtl/muldiv_unit.sv | 155 +++++++++++++++
 tb/tb_muldiv_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage.
// Produces HI/LO for MULT/MULTU/DIV/DIVU; flush aborts without touching outputs.
module muldiv_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             dbz_o
);

    localparam int CMAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] prod_q;
    logic [2*WIDTH-1:0] prod_now;
    logic [WIDTH-1:0]   rem_q, quo_q, dvs_q;
    logic               neg_q, neg_r;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   rem_nx, quo_nx;
    logic [WIDTH-1:0]   q_fix, r_fix;

    // Sign bit extension selects signed or unsigned product.
    function automatic logic [2*WIDTH-1:0] mul_f(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             sgn
    );
        logic [2*WIDTH-1:0] ax, bx;
        ax = {{WIDTH{sgn & a[WIDTH-1]}}, a};
        bx = {{WIDTH{sgn & b[WIDTH-1]}}, b};
        return ax * bx;
    endfunction

    assign prod_now = mul_f(a_i, b_i, ~op_i[0]);

    assign a_neg = ~op_i[0] & a_i[WIDTH-1];
    assign b_neg = ~op_i[0] & b_i[WIDTH-1];
    assign a_mag = a_neg ? -a_i : a_i;
    assign b_mag = b_neg ? -b_i : b_i;

    // Restoring step: shift in next dividend bit, keep the trial if no borrow.
    assign trial  = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
    assign rem_nx = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]}
                                 : trial[WIDTH-1:0];
    assign quo_nx = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    assign q_fix  = neg_q ? -quo_nx : quo_nx;
    assign r_fix  = neg_r ? -rem_nx : rem_nx;

    assign stall_o = start_i & ~done_o;

    // Control FSM plus datapath registers and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            cnt    <= '0;
            hi_o   <= '0;
            lo_o   <= '0;
            done_o <= 1'b0;
            busy_o <= 1'b0;
            dbz_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (flush_i) begin
                state  <= IDLE;
                cnt    <= '0;
                busy_o <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start_i) begin
                            prod_q <= prod_now;
                            rem_q  <= '0;
                            quo_q  <= a_mag;
                            dvs_q  <= b_mag;
                            neg_q  <= a_neg ^ b_neg;
                            neg_r  <= a_neg;
                            cnt    <= op_i[1] ? CW'(0) : CW'(1);
                            if (!op_i[1]) begin
                                if (MUL_LAT == 1) begin
                                    {hi_o, lo_o} <= prod_now;
                                    dbz_o  <= 1'b0;
                                    done_o <= 1'b1;
                                    state  <= DONE;
                                end else begin
                                    busy_o <= 1'b1;
                                    state  <= MUL;
                                end
                            end else if (b_i == '0) begin
                                hi_o   <= a_i;
                                lo_o   <= '1;
                                dbz_o  <= 1'b1;
                                done_o <= 1'b1;
                                state  <= DONE;
                            end else begin
                                busy_o <= 1'b1;
                                state  <= DIV;
                            end
                        end
                    end
                    MUL: begin
                        if (cnt == CW'(MUL_LAT - 1)) begin
                            {hi_o, lo_o} <= prod_q;
                            dbz_o  <= 1'b0;
                            done_o <= 1'b1;
                            busy_o <= 1'b0;
                            cnt    <= '0;
                            state  <= DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DIV: begin
                        rem_q <= rem_nx;
                        quo_q <= quo_nx;
                        if (cnt == CW'(WIDTH - 1)) begin
                            hi_o   <= r_fix;
                            lo_o   <= q_fix;
                            dbz_o  <= 1'b0;
                            done_o <= 1'b1;
                            busy_o <= 1'b0;
                            cnt    <= '0;
                            state  <= DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DONE: begin
                        cnt   <= '0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit.
// Vector table plus random ops through a scoreboard, and hand-written corner sequences.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic        flush_i = 1'b0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        stall_o, busy_o, done_o, dbz_o;
    logic [31:0] hi_o, lo_o;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t        tbl[10];
    vec_t        sb[$];
    logic [31:0] last_hi, last_lo;

    muldiv_unit #(.WIDTH(32), .MUL_LAT(4)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .start_i (start_i),
        .op_i    (op_i),
        .flush_i (flush_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .stall_o (stall_o),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o),
        .dbz_o   (dbz_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] hi,
                                input logic [31:0] lo, input logic dbz,
                                input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b;
        v.hi = hi; v.lo = lo; v.dbz = dbz; v.lat = lat;
        return v;
    endfunction

    function automatic vec_t model(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        vec_t              v;
        longint            sa, sb2;
        longint unsigned   ua, ub;
        logic [63:0]       p;
        sa = longint'($signed(a));
        sb2 = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        v.op = op; v.a = a; v.b = b; v.dbz = 1'b0;
        if (op == 2'b00) begin
            p = sa * sb2;
            v.hi = p[63:32]; v.lo = p[31:0]; v.lat = 4;
        end else if (op == 2'b01) begin
            p = ua * ub;
            v.hi = p[63:32]; v.lo = p[31:0]; v.lat = 4;
        end else if (b == 0) begin
            v.hi = a; v.lo = 32'hFFFF_FFFF; v.dbz = 1'b1; v.lat = 1;
        end else begin
            v.lat = 33;
            if (op == 2'b11) begin
                v.lo = a / b; v.hi = a % b;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                v.lo = 32'h8000_0000; v.hi = 32'h0;
            end else begin
                v.lo = 32'(sa / sb2); v.hi = 32'(sa % sb2);
            end
        end
        return v;
    endfunction

    task automatic do_op(input vec_t v);
        int   cyc;
        bit   got;
        vec_t e;
        start_i = 1'b1;
        op_i = v.op; a_i = v.a; b_i = v.b;
        sb.push_back(v);
        #1 check("stall_c0", 64'(stall_o), 64'd1);
        cyc = 0;
        got = 0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                a_i = $urandom;
                b_i = $urandom;
                if (v.lat > 1) check("busy_c1", 64'(busy_o), 64'd1);
            end
            if (done_o) got = 1;
        end
        e = sb.pop_front();
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: got no done expected done op %0d", e.op);
        end else begin
            check("hi", 64'(hi_o), 64'(e.hi));
            check("lo", 64'(lo_o), 64'(e.lo));
            check("dbz", 64'(dbz_o), 64'(e.dbz));
            check("latency", 64'(cyc), 64'(e.lat));
            check("stall_done", 64'(stall_o), 64'd0);
            last_hi = e.hi;
            last_lo = e.lo;
        end
        start_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int   seen;
        vec_t v;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        tbl[0] = mk(2'b00, 32'hFFFF_FFFD, 32'd7,
                    32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 4);
        tbl[1] = mk(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                    32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 4);
        tbl[2] = mk(2'b10, 32'hFFFF_FFF9, 32'd2,
                    32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
        tbl[3] = mk(2'b11, 32'd100, 32'd0,
                    32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 1);
        tbl[4] = mk(2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
                    32'h0, 32'h8000_0000, 1'b0, 33);
        tbl[5] = mk(2'b10, 32'd7, 32'hFFFF_FFFE,
                    32'd1, 32'hFFFF_FFFD, 1'b0, 33);
        tbl[6] = mk(2'b10, 32'd0, 32'd0,
                    32'd0, 32'hFFFF_FFFF, 1'b1, 1);
        tbl[7] = mk(2'b00, 32'h8000_0000, 32'h8000_0000,
                    32'h4000_0000, 32'h0, 1'b0, 4);
        tbl[8] = mk(2'b11, 32'hFFFF_FFFF, 32'd1,
                    32'h0, 32'hFFFF_FFFF, 1'b0, 33);
        tbl[9] = mk(2'b11, 32'd100, 32'd7,
                    32'd2, 32'd14, 1'b0, 33);

        repeat (3) @(negedge clk);
        check("rst_outs", {hi_o, lo_o}, 64'd0);
        rst_i = 1'b0;
        @(negedge clk);
        check("rst_flags", {61'd0, done_o, busy_o, dbz_o}, 64'd0);

        for (int i = 0; i < 10; i++) do_op(tbl[i]);

        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if (i % 3 == 0) rb = rb >> $urandom_range(0, 31);
            do_op(model(rop, ra, rb));
        end

        // Flush mid-divide: no done, outputs untouched.
        start_i = 1'b1; op_i = 2'b11; a_i = 32'd100; b_i = 32'd7;
        repeat (10) @(negedge clk);
        flush_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        flush_i = 1'b0;
        check("flush_busy", 64'(busy_o), 64'd0);
        seen = 0;
        repeat (30) begin
            if (done_o) seen++;
            @(negedge clk);
        end
        check("flush_nodone", 64'(seen), 64'd0);
        check("flush_hilo", {hi_o, lo_o}, {last_hi, last_lo});
        do_op(mk(2'b01, 32'd6, 32'd7, 32'd0, 32'h2A, 1'b0, 4));

        // Reset during a divide.
        start_i = 1'b1; op_i = 2'b10; a_i = 32'd1000; b_i = 32'd3;
        repeat (5) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        check("rstdiv_hilo", {hi_o, lo_o}, 64'd0);
        check("rstdiv_flags", {61'd0, done_o, busy_o, dbz_o}, 64'd0);
        rst_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk);

        // Back-to-back MULT with start held across DONE.
        start_i = 1'b1; op_i = 2'b00; a_i = 32'd3; b_i = 32'hFFFF_FFFB;
        repeat (4) @(negedge clk);
        check("b2b_done1", 64'(done_o), 64'd1);
        check("b2b_res1", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFF1);
        a_i = 32'hFFFF_FFFE; b_i = 32'hFFFF_FFFC;
        @(negedge clk);
        check("b2b_idle", {62'd0, done_o, busy_o}, 64'd0);
        @(negedge clk);
        check("b2b_busy2", 64'(busy_o), 64'd1);
        repeat (3) @(negedge clk);
        check("b2b_done2", 64'(done_o), 64'd1);
        check("b2b_res2", {hi_o, lo_o}, 64'd8);
        start_i = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
